fetch_mem_unit: RTL and testbench
=================================

FETCH_MEM_UNIT -- requirements
Module: fetch_mem_unit

Interface
REQ-001 Parameter DATA_W, default 16, instruction/data word width.
REQ-002 Parameter ADDR_W, default 16, word-address width.
REQ-003 Parameter RESET_PC, default 0, PC value after reset.
REQ-004 Parameter TIMEOUT, default 15, max wait cycles for bus_ack (used only with FMU_BUSERR_EN).
REQ-005 clock  in  1  all state updates on falling edge.
REQ-006 reset  in  1  synchronous, active-low.
REQ-007 fetch_start  in  1  request instruction fetch at pc.
REQ-008 mem_start  in  1  request data access at mem_addr_in.
REQ-009 mem_we  in  1  data access is a write; sampled with mem_start.
REQ-010 mem_addr_in  in  ADDR_W  data access address.
REQ-011 mem_wdata  in  DATA_W  write data.
REQ-012 pc_update  in  1  commit next PC.
REQ-013 branch_taken  in  1  select branch_target on pc_update.
REQ-014 branch_target  in  ADDR_W  branch destination.
REQ-015 bus_req  out  1  memory request, held until ack.
REQ-016 bus_we  out  1  write strobe qualified by bus_req.
REQ-017 bus_addr  out  ADDR_W  access address.
REQ-018 bus_wdata  out  DATA_W  write data.
REQ-019 bus_rdata  in  DATA_W  read data, valid with bus_ack.
REQ-020 bus_ack  in  1  access complete.
REQ-021 pc, pc_next  out  ADDR_W  current PC; latched pc+1.
REQ-022 ir, mdr  out  DATA_W  instruction register; memory data register.
REQ-023 busy  out  1  state != IDLE.
REQ-024 done  out  1  one-cycle pulse after access completes.
REQ-025 bus_error  out  1  sticky timeout flag (tied 0 without macro).

Function
REQ-026 FSM states IDLE, IFETCH, DACCESS, ERROR (ERROR only with macro).
REQ-027 IDLE + fetch_start -> IFETCH; latch bus_addr<=pc, bus_we<=0, bus_req<=1.
REQ-028 IDLE + mem_start (no fetch_start) -> DACCESS; latch bus_addr<=mem_addr_in, bus_we<=mem_we, bus_wdata<=mem_wdata, bus_req<=1.
REQ-029 fetch_start and mem_start together: fetch wins; mem_start dropped, not queued.
REQ-030 Starts while busy or in ERROR ignored.
REQ-031 bus_addr, bus_we, bus_wdata stable while bus_req=1; may change only on issue.
REQ-032 IFETCH + bus_ack: ir<=bus_rdata, pc_next<=pc+1 (mod 2^ADDR_W), bus_req<=0, -> IDLE, done=1 next cycle.
REQ-033 DACCESS + bus_ack: read: mdr<=bus_rdata; write: mdr unchanged; bus_req<=0, -> IDLE, done=1 next cycle.
REQ-034 Minimum latency: start edge to done = 2 edges with ack high at first wait edge; back-to-back start accepted on the edge done is high.
REQ-035 bus_ack in IDLE/ERROR ignored.
REQ-036 pc_update in any state: pc<=branch_taken ? branch_target : pc_next; in-flight bus_addr unaffected.
REQ-037 pc wraps all-ones -> 0 in pc_next computation.

Reset
REQ-038 reset=0 at falling edge: state IDLE, pc=RESET_PC, pc_next=RESET_PC, ir=0, mdr=0, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, done=0, bus_error=0, wait counter=0.
REQ-039 Reset mid-access abandons it: bus_req drops on the reset edge; no ir/mdr update; no done.

Configuration
REQ-040 Macro FMU_BUSERR_EN defined: wait counter clears on issue, increments each IFETCH/DACCESS edge without ack; at count==TIMEOUT without ack -> ERROR, bus_req<=0, bus_error<=1, sticky until reset.
REQ-041 Ack on the same edge count reaches TIMEOUT: completes normally, no error.
REQ-042 Macro undefined: no counter, no ERROR state, waits indefinitely, bus_error constant 0.

Verification
REQ-043 Reset, fetch_start, ack next cycle rdata=16'h1234 -> ir=16'h1234, pc_next=1, done one cycle, pc=0.
REQ-044 pc=5, pc_update branch_taken=1 target=16'h0040 -> pc=16'h0040; branch_taken=0 -> pc=pc_next.
REQ-045 mem_start write addr=16'h0100 data=16'hBEEF, ack after 3 cycles -> bus_we=1, addr/data stable 3 cycles, mdr unchanged.
REQ-046 fetch_start+mem_start same edge -> IFETCH, bus_addr=pc, no data access follows.
REQ-047 FMU_BUSERR_EN, TIMEOUT=15, no ack -> bus_error=1 after 15 wait edges, bus_req=0, starts ignored until reset; ack at count 15 -> normal done.
REQ-048 pc=16'hFFFF, fetch+ack -> pc_next=0; reset during DACCESS -> bus_req=0, no done.

Source files
------------

// File: rtl/fetch_mem_unit.sv
// fetch_mem_unit: single bus master shared by instruction fetch and data access.
// Define FMU_BUSERR_EN to add the bus_ack timeout counter and sticky ERROR state.
module fetch_mem_unit #(
    parameter int          DATA_W   = 16,
    parameter int          ADDR_W   = 16,
    parameter int unsigned RESET_PC = 0,
    parameter int          TIMEOUT  = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              fetch_start,
    input  logic              mem_start,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr_in,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic              pc_update,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ack,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_next,
    output logic [DATA_W-1:0] ir,
    output logic [DATA_W-1:0] mdr,
    output logic              busy,
    output logic              done,
    output logic              bus_error
);

    localparam logic [ADDR_W-1:0] PC_RST = ADDR_W'(RESET_PC);

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("TIMEOUT must be at least 1");
    end

`ifdef FMU_BUSERR_EN
    typedef enum logic [1:0] {IDLE, IFETCH, DACCESS, ERROR} state_t;
`else
    typedef enum logic [1:0] {IDLE, IFETCH, DACCESS} state_t;
`endif

    state_t state_q, state_d;
    logic   issue_f, issue_m, finish;

`ifdef FMU_BUSERR_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] wait_q;
    logic             err_q;
    logic             give_up;
    logic             timeout_hit;

    // The edge that would make the count reach TIMEOUT is the last one allowed.
    assign timeout_hit = (wait_q + CNT_W'(1)) == CNT_W'(TIMEOUT);
    assign bus_error   = err_q;
`else
    assign bus_error = 1'b0;
`endif

    assign busy = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        issue_f = 1'b0;
        issue_m = 1'b0;
        finish  = 1'b0;
`ifdef FMU_BUSERR_EN
        give_up = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (fetch_start) begin
                    issue_f = 1'b1;
                    state_d = IFETCH;
                end else if (mem_start) begin
                    issue_m = 1'b1;
                    state_d = DACCESS;
                end
            end
            IFETCH, DACCESS: begin
                if (bus_ack) begin
                    finish  = 1'b1;
                    state_d = IDLE;
                end
`ifdef FMU_BUSERR_EN
                else if (timeout_hit) begin
                    give_up = 1'b1;
                    state_d = ERROR;
                end
`endif
            end
`ifdef FMU_BUSERR_EN
            ERROR: state_d = ERROR;
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(negedge clock) begin
        if (!reset) begin
            state_q   <= IDLE;
            pc        <= PC_RST;
            pc_next   <= PC_RST;
            ir        <= '0;
            mdr       <= '0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            done      <= 1'b0;
`ifdef FMU_BUSERR_EN
            wait_q    <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            done    <= finish;

            if (issue_f) begin
                bus_addr <= pc;
                bus_we   <= 1'b0;
                bus_req  <= 1'b1;
            end

            if (issue_m) begin
                bus_addr  <= mem_addr_in;
                bus_we    <= mem_we;
                bus_wdata <= mem_wdata;
                bus_req   <= 1'b1;
            end

            if (finish) begin
                bus_req <= 1'b0;
                if (state_q == IFETCH) begin
                    ir      <= bus_rdata;
                    pc_next <= pc + ADDR_W'(1);
                end else if (!bus_we) begin
                    mdr <= bus_rdata;
                end
            end

`ifdef FMU_BUSERR_EN
            if (issue_f || issue_m) begin
                wait_q <= '0;
            end else if ((state_q == IFETCH || state_q == DACCESS)
                         && !bus_ack) begin
                wait_q <= wait_q + CNT_W'(1);
            end

            if (give_up) begin
                bus_req <= 1'b0;
                err_q   <= 1'b1;
            end
`endif

            // bus_addr was captured at issue, so a PC commit never disturbs it.
            if (pc_update) begin
                pc <= branch_taken ? branch_target : pc_next;
            end
        end
    end

endmodule

// File: tb/tb_fetch_mem_unit.sv
// tb_fetch_mem_unit: scoreboard bench for fetch_mem_unit.
// Drives on the falling-edge clock and samples 1 time unit after each edge.
module tb_fetch_mem_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        fetch_start = 1'b0;
    logic        mem_start = 1'b0;
    logic        mem_we = 1'b0;
    logic [15:0] mem_addr_in = '0;
    logic [15:0] mem_wdata = '0;
    logic        pc_update = 1'b0;
    logic        branch_taken = 1'b0;
    logic [15:0] branch_target = '0;
    logic        bus_req, bus_we;
    logic [15:0] bus_addr, bus_wdata;
    logic [15:0] bus_rdata = '0;
    logic        bus_ack = 1'b0;
    logic [15:0] pc, pc_next, ir, mdr;
    logic        busy, done, bus_error;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [15:0] ir;
        logic [15:0] mdr;
        logic [15:0] pcn;
    } exp_t;

    exp_t sb[$];

    logic [15:0] m_pc, m_pcn, m_ir, m_mdr;

    fetch_mem_unit dut (
        .clock(clock), .reset(reset),
        .fetch_start(fetch_start), .mem_start(mem_start),
        .mem_we(mem_we), .mem_addr_in(mem_addr_in),
        .mem_wdata(mem_wdata), .pc_update(pc_update),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
        .bus_ack(bus_ack), .pc(pc), .pc_next(pc_next),
        .ir(ir), .mdr(mdr), .busy(busy), .done(done),
        .bus_error(bus_error)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        fetch_start = 1'b0;
        mem_start = 1'b0;
        pc_update = 1'b0;
        bus_ack = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        m_pc = 16'h0;
        m_pcn = 16'h0;
        m_ir = 16'h0;
        m_mdr = 16'h0;
    endtask

    task automatic do_pc_update(input bit taken, input logic [15:0] tgt);
        pc_update = 1'b1;
        branch_taken = taken;
        branch_target = tgt;
        tick();
        pc_update = 1'b0;
        branch_taken = 1'b0;
        m_pc = taken ? tgt : m_pcn;
    endtask

    // Issues one access, holds ack low for dly wait edges, then acks it.
    task automatic access(
        input bit f, input bit m, input bit we,
        input logic [15:0] addr, input logic [15:0] wd,
        input logic [15:0] rd, input int dly,
        output logic [15:0] o_addr, output logic o_we,
        output logic [15:0] o_wd, output bit stable,
        output bit pulse);
        fetch_start = f;
        mem_start = m;
        mem_we = we;
        mem_addr_in = addr;
        mem_wdata = wd;
        tick();
        fetch_start = 1'b0;
        mem_start = 1'b0;
        o_addr = bus_addr;
        o_we = bus_we;
        o_wd = bus_wdata;
        stable = (bus_req === 1'b1);
        repeat (dly) begin
            tick();
            if (bus_req !== 1'b1 || bus_addr !== o_addr ||
                bus_we !== o_we || bus_wdata !== o_wd)
                stable = 1'b0;
        end
        bus_ack = 1'b1;
        bus_rdata = rd;
        tick();
        bus_ack = 1'b0;
        pulse = (done === 1'b1);
        tick();
        if (done !== 1'b0) pulse = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({pc, pc_next, ir, mdr} !== 64'h0) begin
            n_err++;
            $display("FAIL reset_regs: got %h want 0",
                     {pc, pc_next, ir, mdr});
        end
        n_cmp++;
        if ({bus_req, bus_we, busy, done, bus_error} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b want 00000",
                     {bus_req, bus_we, busy, done, bus_error});
        end
        n_cmp++;
        if ({bus_addr, bus_wdata} !== 32'h0) begin
            n_err++;
            $display("FAIL reset_bus: got %h want 0",
                     {bus_addr, bus_wdata});
        end
    endtask

    task automatic test_fetch();
        logic [15:0] a, w;
        logic we;
        bit st, pl;
        exp_t e;
        sb.push_back('{ir: 16'h1234, mdr: m_mdr, pcn: m_pc + 16'h1});
        access(1, 0, 0, 16'h0, 16'h0, 16'h1234, 0, a, we, w, st, pl);
        e = sb.pop_front();
        m_ir = e.ir;
        m_pcn = e.pcn;
        n_cmp++;
        if ({a, we, st} !== {m_pc, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL fetch_issue: got %h/%b/%b want %h/0/1",
                     a, we, st, m_pc);
        end
        n_cmp++;
        if (!pl) begin
            n_err++;
            $display("FAIL fetch_done: got no 1-cycle pulse want one");
        end
        n_cmp++;
        if ({ir, pc_next, pc} !== {e.ir, e.pcn, m_pc}) begin
            n_err++;
            $display("FAIL fetch_result: got %h want %h",
                     {ir, pc_next, pc}, {e.ir, e.pcn, m_pc});
        end
    endtask

    task automatic test_branch();
        logic [15:0] a, w;
        logic we;
        bit st, pl;
        exp_t e;
        do_pc_update(1, 16'h0005);
        n_cmp++;
        if (pc !== 16'h0005) begin
            n_err++;
            $display("FAIL branch_5: got %h want 0005", pc);
        end
        sb.push_back('{ir: 16'hABCD, mdr: m_mdr, pcn: m_pc + 16'h1});
        access(1, 0, 0, 16'h0, 16'h0, 16'hABCD, 1, a, we, w, st, pl);
        e = sb.pop_front();
        m_ir = e.ir;
        m_pcn = e.pcn;
        n_cmp++;
        if ({a, ir, pc_next} !== {16'h0005, e.ir, e.pcn}) begin
            n_err++;
            $display("FAIL fetch_at_5: got %h want %h",
                     {a, ir, pc_next}, {16'h0005, e.ir, e.pcn});
        end
        do_pc_update(1, 16'h0040);
        n_cmp++;
        if (pc !== 16'h0040) begin
            n_err++;
            $display("FAIL branch_taken: got %h want 0040", pc);
        end
        do_pc_update(0, 16'h0777);
        n_cmp++;
        if (pc !== m_pc) begin
            n_err++;
            $display("FAIL branch_not_taken: got %h want %h", pc, m_pc);
        end
    endtask

    task automatic test_mem();
        logic [15:0] a, w;
        logic we;
        bit st, pl;
        exp_t e;
        sb.push_back('{ir: m_ir, mdr: 16'h5A5A, pcn: m_pcn});
        access(0, 1, 0, 16'h0200, 16'h0, 16'h5A5A, 2, a, we, w, st, pl);
        e = sb.pop_front();
        m_mdr = e.mdr;
        n_cmp++;
        if ({a, we, st, pl} !== {16'h0200, 1'b0, 1'b1, 1'b1}) begin
            n_err++;
            $display("FAIL mem_read_bus: got %h/%b/%b/%b want 0200/0/1/1",
                     a, we, st, pl);
        end
        n_cmp++;
        if ({mdr, ir} !== {e.mdr, e.ir}) begin
            n_err++;
            $display("FAIL mem_read_mdr: got %h want %h",
                     {mdr, ir}, {e.mdr, e.ir});
        end
        sb.push_back('{ir: m_ir, mdr: m_mdr, pcn: m_pcn});
        access(0, 1, 1, 16'h0100, 16'hBEEF, 16'hFFFF, 3, a, we, w, st, pl);
        e = sb.pop_front();
        n_cmp++;
        if ({a, w, we} !== {16'h0100, 16'hBEEF, 1'b1}) begin
            n_err++;
            $display("FAIL mem_write_bus: got %h/%h/%b want 0100/beef/1",
                     a, w, we);
        end
        n_cmp++;
        if (!st || !pl) begin
            n_err++;
            $display("FAIL mem_write_hold: got stable=%b done=%b want 1/1",
                     st, pl);
        end
        n_cmp++;
        if ({mdr, ir, pc_next} !== {e.mdr, e.ir, e.pcn}) begin
            n_err++;
            $display("FAIL mem_write_mdr: got %h want %h",
                     {mdr, ir, pc_next}, {e.mdr, e.ir, e.pcn});
        end
    endtask

    task automatic test_priority();
        logic [15:0] a, w;
        logic we;
        bit st, pl;
        bit extra;
        exp_t e;
        sb.push_back('{ir: 16'h4242, mdr: m_mdr, pcn: m_pc + 16'h1});
        access(1, 1, 1, 16'h0300, 16'h1111, 16'h4242, 0, a, we, w, st, pl);
        e = sb.pop_front();
        m_ir = e.ir;
        m_pcn = e.pcn;
        extra = 1'b0;
        repeat (4) begin
            tick();
            if (bus_req !== 1'b0 || busy !== 1'b0) extra = 1'b1;
        end
        n_cmp++;
        if ({a, we} !== {m_pc, 1'b0}) begin
            n_err++;
            $display("FAIL prio_issue: got %h/%b want %h/0", a, we, m_pc);
        end
        n_cmp++;
        if (extra) begin
            n_err++;
            $display("FAIL prio_dropped: got data access want none");
        end
        n_cmp++;
        if ({ir, mdr, pc_next} !== {e.ir, e.mdr, e.pcn}) begin
            n_err++;
            $display("FAIL prio_result: got %h want %h",
                     {ir, mdr, pc_next}, {e.ir, e.mdr, e.pcn});
        end
    endtask

    task automatic test_busy_ignore();
        bit extra;
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        mem_start = 1'b1;
        mem_we = 1'b1;
        mem_addr_in = 16'h0999;
        tick();
        tick();
        mem_start = 1'b0;
        n_cmp++;
        if ({bus_addr, bus_we, bus_req} !== {m_pc, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL busy_ignore: got %h/%b/%b want %h/0/1",
                     bus_addr, bus_we, bus_req, m_pc);
        end
        sb.push_back('{ir: 16'h1111, mdr: m_mdr, pcn: m_pc + 16'h1});
        bus_ack = 1'b1;
        bus_rdata = 16'h1111;
        tick();
        bus_ack = 1'b0;
        extra = 1'b0;
        repeat (3) begin
            tick();
            if (bus_req !== 1'b0) extra = 1'b1;
        end
        begin
            exp_t e;
            e = sb.pop_front();
            m_ir = e.ir;
            m_pcn = e.pcn;
            n_cmp++;
            if (extra || ir !== e.ir) begin
                n_err++;
                $display("FAIL busy_after: got ir=%h extra=%b want %h/0",
                         ir, extra, e.ir);
            end
        end
        bus_ack = 1'b1;
        bus_rdata = 16'h2222;
        tick();
        extra = (done !== 1'b0);
        tick();
        bus_ack = 1'b0;
        if (done !== 1'b0) extra = 1'b1;
        n_cmp++;
        if (extra || {ir, mdr} !== {m_ir, m_mdr}) begin
            n_err++;
            $display("FAIL idle_ack: got %h done=%b want %h done=0",
                     {ir, mdr}, extra, {m_ir, m_mdr});
        end
    endtask

    task automatic test_back_to_back();
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        bus_ack = 1'b1;
        bus_rdata = 16'h0A0A;
        tick();
        bus_ack = 1'b0;
        m_ir = 16'h0A0A;
        m_pcn = m_pc + 16'h1;
        n_cmp++;
        if ({done, busy} !== 2'b10) begin
            n_err++;
            $display("FAIL b2b_first: got done/busy=%b%b want 10",
                     done, busy);
        end
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        n_cmp++;
        if ({bus_req, done, bus_addr} !== {1'b1, 1'b0, m_pc}) begin
            n_err++;
            $display("FAIL b2b_accept: got %b/%b/%h want 1/0/%h",
                     bus_req, done, bus_addr, m_pc);
        end
        bus_ack = 1'b1;
        bus_rdata = 16'h0B0B;
        tick();
        bus_ack = 1'b0;
        m_ir = 16'h0B0B;
        n_cmp++;
        if ({done, ir} !== {1'b1, m_ir}) begin
            n_err++;
            $display("FAIL b2b_second: got %b/%h want 1/%h",
                     done, ir, m_ir);
        end
        tick();
    endtask

    task automatic test_wrap();
        logic [15:0] a, w;
        logic we;
        bit st, pl;
        exp_t e;
        do_pc_update(1, 16'hFFFF);
        sb.push_back('{ir: 16'h7E7E, mdr: m_mdr, pcn: 16'h0000});
        access(1, 0, 0, 16'h0, 16'h0, 16'h7E7E, 0, a, we, w, st, pl);
        e = sb.pop_front();
        m_pcn = e.pcn;
        n_cmp++;
        if ({a, pc_next} !== {16'hFFFF, e.pcn}) begin
            n_err++;
            $display("FAIL pc_wrap: got %h want %h",
                     {a, pc_next}, {16'hFFFF, e.pcn});
        end
        do_pc_update(0, 16'h1234);
        n_cmp++;
        if (pc !== 16'h0000) begin
            n_err++;
            $display("FAIL pc_wrap_commit: got %h want 0000", pc);
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        mem_start = 1'b1;
        mem_we = 1'b0;
        mem_addr_in = 16'h0321;
        tick();
        mem_start = 1'b0;
        n_cmp++;
        if (bus_req !== 1'b1) begin
            n_err++;
            $display("FAIL rst_mid_issue: got bus_req=%b want 1", bus_req);
        end
        reset = 1'b0;
        bus_ack = 1'b1;
        bus_rdata = 16'h7777;
        tick();
        bus_ack = 1'b0;
        seen = (done !== 1'b0);
        n_cmp++;
        if ({bus_req, busy, mdr} !== {1'b0, 1'b0, 16'h0}) begin
            n_err++;
            $display("FAIL rst_mid_abort: got %b/%b/%h want 0/0/0000",
                     bus_req, busy, mdr);
        end
        reset = 1'b1;
        repeat (2) begin
            tick();
            if (done !== 1'b0) seen = 1'b1;
        end
        n_cmp++;
        if (seen || mdr !== 16'h0) begin
            n_err++;
            $display("FAIL rst_mid_done: got done=%b mdr=%h want 0/0000",
                     seen, mdr);
        end
        m_pc = 16'h0;
        m_pcn = 16'h0;
        m_ir = 16'h0;
        m_mdr = 16'h0;
    endtask

`ifdef FMU_BUSERR_EN
    task automatic test_timeout();
        do_reset();
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        repeat (14) tick();
        n_cmp++;
        if ({bus_error, bus_req} !== 2'b01) begin
            n_err++;
            $display("FAIL to_before: got %b%b want 01", bus_error, bus_req);
        end
        tick();
        n_cmp++;
        if ({bus_error, bus_req, busy} !== 3'b101) begin
            n_err++;
            $display("FAIL to_hit: got %b want 101",
                     {bus_error, bus_req, busy});
        end
        fetch_start = 1'b1;
        bus_ack = 1'b1;
        tick();
        fetch_start = 1'b0;
        bus_ack = 1'b0;
        n_cmp++;
        if ({bus_error, bus_req, done} !== 3'b100) begin
            n_err++;
            $display("FAIL to_sticky: got %b want 100",
                     {bus_error, bus_req, done});
        end
        do_reset();
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        repeat (14) tick();
        bus_ack = 1'b1;
        bus_rdata = 16'hCAFE;
        tick();
        bus_ack = 1'b0;
        n_cmp++;
        if ({done, bus_error, ir} !== {2'b10, 16'hCAFE}) begin
            n_err++;
            $display("FAIL to_ack_last: got %b/%b/%h want 1/0/cafe",
                     done, bus_error, ir);
        end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_fetch();
        test_branch();
        test_mem();
        test_priority();
        test_busy_ignore();
        test_back_to_back();
        test_wrap();
        test_reset_mid();
`ifdef FMU_BUSERR_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
